// File: rtl/spi_mem_responder_if.sv
// spi_mem_responder_if
// Memory-side bus between the SPI responder and a synchronous single-port RAM.
//   mem_addr_o   : RAM address (held between frames)
//   mem_wdata_o  : RAM write data (held between frames)
//   mem_we_o     : one-clk write strobe
//   mem_re_o     : one-clk read strobe, mem_rdata_i valid on the following clk
//   mem_rdata_i  : RAM read data
// Modport master is the responder side, modport slave is the RAM side.
interface spi_mem_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_addr_o,
    output mem_wdata_o,
    output mem_we_o,
    output mem_re_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_we_o,
    input  mem_re_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/spi_mem_responder.sv
// spi_mem_responder
// SPI mode-0 target at the memory end of the CPU control link. Each frame is
// rwb (1 = read) + ADDR_W address bits + DATA_W data bits, MSB first. A frame
// performs exactly one RAM access; read data is shifted back in the data phase
// of the same frame. All SPI pins are oversampled in the clk domain.
// Ports:
//   clk, resetb      : system clock, asynchronous active-low reset
//   sclk_i, csb_i    : SPI clock and active-low chip select from the initiator
//   mosi_i, miso_o   : serial data in / out
//   miso_oe_o        : MISO drive enable, high while synchronized csb is low
//   busy_o           : high whenever the FSM is not IDLE
//   frame_err_o      : one-clk pulse when a frame is aborted early
//   mem              : RAM bus (spi_mem_responder_if master modport)
module spi_mem_responder #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     sclk_i,
  input  logic                     csb_i,
  input  logic                     mosi_i,
  output logic                     miso_o,
  output logic                     miso_oe_o,
  output logic                     busy_o,
  output logic                     frame_err_o,
  spi_mem_responder_if.master      mem
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_WAIT,
    DATA,
    COMMIT,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] csb_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   csb_prev;
  logic                   sclk_s;
  logic                   csb_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   csb_fall;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [FRAME_W-2:0] shift_q, shift_n;
  logic [FRAME_W-1:0] shift_in;
  logic [DATA_W-1:0] tx_q, tx_n;
  logic              miso_q, miso_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              err_q, err_n;

  // Multi-stage synchronizers on the SPI pins plus one extra delayed copy of
  // sclk and csb for edge detection. They clear to the idle bus levels so a
  // reset never looks like a csb fall or an sclk edge.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      csb_prev  <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      sclk_prev <= sclk_s;
      csb_prev  <= csb_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign csb_fall  = ~csb_s & csb_prev;

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      miso_q  <= miso_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      err_q   <= err_n;
    end
  end

  // Frame sequencing. csb is tested as a level in the mid-frame states, so a
  // release is caught even if it lands during a one-clk state. In DATA the
  // final sclk rise is checked before csb so a release coinciding with the
  // last bit still completes the frame.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shift_n  = shift_q;
    tx_n     = tx_q;
    miso_n   = miso_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    err_n    = 1'b0;
    shift_in = {shift_q, mosi_s};

    case (state_q)
      IDLE: begin
        if (csb_fall) begin
          state_n = CMD;
          cnt_n   = '0;
          shift_n = '0;
          miso_n  = 1'b0;
        end
      end

      CMD: begin
        if (csb_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
          miso_n  = 1'b0;
        end else if (sclk_rise) begin
          shift_n = shift_in[FRAME_W-2:0];
          cnt_n   = cnt_q + CNT_W'(1);
          if (cnt_q == CMD_LAST) begin
            addr_n = shift_in[ADDR_W-1:0];
            if (shift_in[ADDR_W]) begin
              state_n = RD_REQ;
            end else begin
              state_n = DATA;
              tx_n    = '0;
            end
          end
        end
      end

      RD_REQ: begin
        if (csb_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
          miso_n  = 1'b0;
        end else begin
          state_n = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (csb_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
          miso_n  = 1'b0;
        end else begin
          tx_n    = mem.mem_rdata_i;
          state_n = DATA;
        end
      end

      DATA: begin
        if (sclk_rise && (cnt_q == FRAME_LAST)) begin
          shift_n = shift_in[FRAME_W-2:0];
          cnt_n   = cnt_q + CNT_W'(1);
          miso_n  = 1'b0;
          if (shift_in[FRAME_W-1]) begin
            state_n = DONE;
          end else begin
            wdata_n = shift_in[DATA_W-1:0];
            state_n = COMMIT;
          end
        end else if (csb_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
          miso_n  = 1'b0;
        end else if (sclk_rise) begin
          shift_n = shift_in[FRAME_W-2:0];
          cnt_n   = cnt_q + CNT_W'(1);
        end else if (sclk_fall) begin
          miso_n = tx_q[DATA_W-1];
          tx_n   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end

      COMMIT: begin
        state_n = DONE;
      end

      DONE: begin
        miso_n = 1'b0;
        if (csb_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign miso_o          = miso_q;
  assign miso_oe_o       = ~csb_s;
  assign busy_o          = (state_q != IDLE);
  assign frame_err_o     = err_q;
  assign mem.mem_addr_o  = addr_q;
  assign mem.mem_wdata_o = wdata_q;
  assign mem.mem_we_o    = (state_q == COMMIT);
  assign mem.mem_re_o    = (state_q == RD_REQ);

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
SPI target (responder) at the memory end of the 32-bit SPI link the CPU control path uses for instruction fetch, memory read and memory write. It decodes each frame into a command (rwb, address), performs one access on a synchronous single-port RAM, and returns read data in the same frame. SPI pins are oversampled in the system clock domain; the block serves ROM/RAM models on the board and the bench.

Parameters:
ADDR_W, 15, address field width
DATA_W, 16, data field width; frame length FRAME_W = 1+ADDR_W+DATA_W (32 at defaults)
SYNC_STAGES, 2, synchronizer depth on sclk_i, csb_i, mosi_i (min 2)

Ports:
clk  input  1  system clock
resetb  input  1  asynchronous active-low reset
sclk_i  input  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0)
csb_i  input  1  SPI chip select, active low, frames one transaction
mosi_i  input  1  serial data in, MSB first
miso_o  output  1  serial data out, MSB first
miso_oe_o  output  1  MISO drive enable, high while synchronized csb low
mem_addr_o  output  ADDR_W  RAM address
mem_wdata_o  output  DATA_W  RAM write data
mem_we_o  output  1  RAM write strobe, one clk pulse
mem_re_o  output  1  RAM read strobe, one clk pulse; mem_rdata_i valid on the next clk
mem_rdata_i  input  DATA_W  RAM read data
busy_o  output  1  high in any state but IDLE
frame_err_o  output  1  one-clk pulse on a frame aborted before FRAME_W bits

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, shift registers 0, synchronizers cleared to sclk=0, csb=1.
- Edge detect on synchronized sclk: rise = sample MOSI, fall = update MISO. Constraint: SCLK half period >= 4 clk (SCLK <= clk/8).
- Frame: bit FRAME_W-1 = rwb (1 read, 0 write), next ADDR_W bits address, last DATA_W bits write data (ignored on read).
- States: IDLE, CMD, RD_REQ, RD_WAIT, DATA, COMMIT, DONE.
- IDLE: on synchronized csb falling -> CMD, counter 0, miso_o 0.
- CMD: shift MOSI on each rise; after rise 1+ADDR_W -> latch mem_addr_o; rwb=1 -> RD_REQ, rwb=0 -> DATA.
- RD_REQ: mem_re_o=1 one clk -> RD_WAIT. RD_WAIT: load mem_rdata_i into TX shift register -> DATA.
- DATA: each fall drives next TX bit on miso_o (first fall after address drives bit DATA_W-1); each rise shifts MOSI into RX. miso_o 0 during CMD and for writes.
- After rise FRAME_W: write -> COMMIT (mem_wdata_o = RX, mem_we_o one clk) -> DONE; read -> DONE directly.
- DONE: further sclk edges ignored, miso_o held 0; csb rise -> IDLE.
- csb rise in CMD/RD_REQ/RD_WAIT/DATA: abort, no write issued (an issued read completes harmlessly), frame_err_o pulse, -> IDLE.
- csb rise and final sclk rise in same clk: final rise wins, frame completes (write committed), then IDLE.
- Exactly one memory access per frame; mem_addr_o/mem_wdata_o hold last value between frames.
- Reset mid-frame: immediate return to reset values, no strobe.

Test Plan:
- Write frame 0x0005_1234 (rwb=0, addr 0x0005, data 0x1234) at clk/8 -> single mem_we_o pulse with addr 0x0005, wdata 0x1234 after rise 32; no mem_re_o; miso_o 0 all frame.
- Read frame 0x8005_0000 with RAM[5]=0xBEEF -> mem_re_o once after rise 16; bits 17..32 sampled by initiator = 0xBEEF; no mem_we_o.
- Back-to-back write 0x7FFF/0xFFFF then read 0x7FFF -> read returns 0xFFFF; busy_o low between frames.
- csb released after 20 bits of a write -> frame_err_o pulse, no mem_we_o, next valid frame decodes correctly.
- 40 sclk pulses in one write frame -> exactly one write with first 32 bits; extra pulses ignored.
- resetb low at bit 24 of a read -> outputs 0 immediately, no strobes; next frame decodes correctly.
